// File: rtl/fetch_pc_unit.sv
// Program counter and instruction fetch stage: fetches over a req/ack handshake,
// holds the word for decode, and steers the PC from jr/jump/branch on accept.
module fetch_pc_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        instr_valid,
    output logic [31:0] instr,
    output logic [31:0] pc_out,
    output logic [31:0] pc_plus4,
    input  logic        instr_accept,
    input  logic        branch_taken,
    input  logic [15:0] branch_offset,
    input  logic        jump,
    input  logic [25:0] jump_target,
    input  logic        jr,
    input  logic [31:0] jr_addr,
    output logic [31:0] retired_count
);

    typedef enum logic [1:0] {
        ST_RESET = 2'd0,
        ST_FETCH = 2'd1,
        ST_HOLD  = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] retired_q, retired_d;
    logic        ack_fire;
    logic        accept_fire;

    // Redirect priority: jr > jump > taken branch > fall-through.
    function automatic logic [31:0] calc_next_pc(
        input logic [31:0] pc4,
        input logic        jr_i,
        input logic [31:0] jr_addr_i,
        input logic        jump_i,
        input logic [25:0] target_i,
        input logic        br_i,
        input logic [15:0] offset_i
    );
        logic signed [31:0] disp;
        disp = {{14{offset_i[15]}}, offset_i, 2'b00};
        if (jr_i)
            calc_next_pc = jr_addr_i & 32'hFFFF_FFFC;
        else if (jump_i)
            calc_next_pc = {pc4[31:28], target_i, 2'b00};
        else if (br_i)
            calc_next_pc = pc4 + $unsigned(disp);
        else
            calc_next_pc = pc4;
    endfunction

    assign pc_plus4    = pc_q + 32'd4;
    assign ack_fire    = (state_q == ST_FETCH) && imem_ack;
    assign accept_fire = (state_q == ST_HOLD) && instr_accept;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_RESET;
            pc_q      <= RESET_PC;
            instr_q   <= 32'h0000_0000;
            retired_q <= 32'h0000_0000;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            instr_q   <= instr_d;
            retired_q <= retired_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RESET: state_d = ST_FETCH;
            ST_FETCH: if (imem_ack) state_d = ST_HOLD;
            ST_HOLD:  if (instr_accept) state_d = ST_FETCH;
            default:  state_d = ST_RESET;
        endcase
    end

    always_comb begin
        pc_d      = pc_q;
        instr_d   = instr_q;
        retired_d = retired_q;
        if (ack_fire)
            instr_d = imem_rdata;
        if (accept_fire) begin
            pc_d      = calc_next_pc(pc_plus4, jr, jr_addr, jump, jump_target,
                                     branch_taken, branch_offset);
            retired_d = retired_q + 32'd1;
        end
    end

    always_comb begin
        imem_req    = (state_q == ST_FETCH);
        instr_valid = (state_q == ST_HOLD);
    end

    assign imem_addr     = pc_q;
    assign pc_out        = pc_q;
    assign instr         = instr_q;
    assign retired_count = retired_q;

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Directed bench for fetch_pc_unit: reset, sequential fetch, redirect priority,
// branches, wait states, wrap and asynchronous reset during a fetch.
module tb_fetch_pc_unit;

    localparam logic [31:0] RPC = 32'h0040_0000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] pc_out;
    logic [31:0] pc_plus4;
    logic        instr_accept;
    logic        branch_taken;
    logic [15:0] branch_offset;
    logic        jump;
    logic [25:0] jump_target;
    logic        jr;
    logic [31:0] jr_addr;
    logic [31:0] retired_count;

    int          total = 0;
    int          bad   = 0;
    logic [31:0] exp_ret = 32'd0;

    fetch_pc_unit #(.RESET_PC(RPC)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_ack      (imem_ack),
        .imem_rdata    (imem_rdata),
        .instr_valid   (instr_valid),
        .instr         (instr),
        .pc_out        (pc_out),
        .pc_plus4      (pc_plus4),
        .instr_accept  (instr_accept),
        .branch_taken  (branch_taken),
        .branch_offset (branch_offset),
        .jump          (jump),
        .jump_target   (jump_target),
        .jr            (jr),
        .jr_addr       (jr_addr)
        ,.retired_count (retired_count)
    );

    always #5 clk = ~clk;

    // Stimulus only: present the word after wait_cycles idle cycles, then drop ack.
    task automatic run_fetch(input logic [31:0] rdata, input int wait_cycles);
        repeat (wait_cycles) @(negedge clk);
        imem_ack   = 1'b1;
        imem_rdata = rdata;
        @(negedge clk);
        imem_ack   = 1'b0;
    endtask

    task automatic run_accept(input logic jr_i, input logic [31:0] jra,
                              input logic jmp, input logic [25:0] tgt,
                              input logic br, input logic [15:0] off);
        jr = jr_i; jr_addr = jra; jump = jmp; jump_target = tgt;
        branch_taken = br; branch_offset = off; instr_accept = 1'b1;
        @(negedge clk);
        jr = 1'b0; jr_addr = '0; jump = 1'b0; jump_target = '0;
        branch_taken = 1'b0; branch_offset = '0; instr_accept = 1'b0;
        exp_ret = exp_ret + 32'd1;
    endtask

    task automatic test_reset;
        rst_n = 1'b0; imem_ack = 1'b0; imem_rdata = '0; instr_accept = 1'b0;
        branch_taken = 1'b0; branch_offset = '0; jump = 1'b0; jump_target = '0;
        jr = 1'b0; jr_addr = '0;
        @(negedge clk);
        total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL rst_req got=%b exp=0", imem_req); end
        total++; if (instr_valid !== 1'b0) begin bad++; $display("FAIL rst_valid got=%b exp=0", instr_valid); end
        total++; if (instr !== 32'h0) begin bad++; $display("FAIL rst_instr got=%h exp=0", instr); end
        total++; if (retired_count !== 32'h0) begin bad++; $display("FAIL rst_retired got=%h exp=0", retired_count); end
        total++; if (pc_out !== RPC || imem_addr !== RPC) begin bad++; $display("FAIL rst_pc got=%h/%h exp=%h", pc_out, imem_addr, RPC); end
        rst_n = 1'b1;
        @(posedge clk); #1;
        total++; if (imem_req !== 1'b1 || imem_addr !== RPC) begin bad++; $display("FAIL rst_first_req got=%b/%h exp=1/%h", imem_req, imem_addr, RPC); end
        @(negedge clk);
    endtask

    task automatic test_sequential;
        logic [31:0] a;
        for (int i = 0; i < 3; i++) begin
            a = RPC + 32'(4 * i);
            total++; if (imem_req !== 1'b1 || imem_addr !== a) begin bad++; $display("FAIL seq_addr%0d got=%b/%h exp=1/%h", i, imem_req, imem_addr, a); end
            run_fetch(32'h1000_0000 + a, 0);
            total++; if (instr_valid !== 1'b1 || instr !== 32'h1000_0000 + a || pc_plus4 !== a + 32'd4) begin
                bad++; $display("FAIL seq_instr%0d got=%b/%h/%h exp=1/%h/%h", i, instr_valid, instr, pc_plus4, 32'h1000_0000 + a, a + 32'd4); end
            run_accept(1'b0, '0, 1'b0, '0, 1'b0, '0);
        end
        total++; if (retired_count !== 32'd3) begin bad++; $display("FAIL seq_retired got=%0d exp=3", retired_count); end
        total++; if (imem_addr !== 32'h0040_000C) begin bad++; $display("FAIL seq_next got=%h exp=0040000c", imem_addr); end
    endtask

    task automatic test_priority;
        run_fetch(32'hAAAA_0001, 0);
        run_accept(1'b1, 32'h0000_2003, 1'b1, 26'h3FF_FFFF, 1'b1, 16'h0010);
        total++; if (imem_addr !== 32'h0000_2000 || imem_req !== 1'b1) begin bad++; $display("FAIL prio_jr got=%h exp=00002000", imem_addr); end
        run_fetch(32'hAAAA_0002, 1);
        run_accept(1'b1, 32'h1000_0000, 1'b0, '0, 1'b0, '0);
        run_fetch(32'hAAAA_0003, 0);
        run_accept(1'b0, '0, 1'b1, 26'h000_0040, 1'b1, 16'h0004);
        total++; if (imem_addr !== 32'h1000_0100) begin bad++; $display("FAIL prio_jump got=%h exp=10000100", imem_addr); end
    endtask

    task automatic test_branch;
        run_fetch(32'hBBBB_0001, 0);
        run_accept(1'b1, 32'h0000_0100, 1'b0, '0, 1'b0, '0);
        run_fetch(32'hBBBB_0002, 0);
        run_accept(1'b0, '0, 1'b0, '0, 1'b1, 16'hFFFE);
        total++; if (imem_addr !== 32'h0000_00FC) begin bad++; $display("FAIL br_back got=%h exp=000000fc", imem_addr); end
        run_fetch(32'hBBBB_0003, 0);
        run_accept(1'b1, 32'h0000_0100, 1'b0, '0, 1'b0, '0);
        run_fetch(32'hBBBB_0004, 0);
        run_accept(1'b0, '0, 1'b0, '0, 1'b1, 16'h0003);
        total++; if (imem_addr !== 32'h0000_0110) begin bad++; $display("FAIL br_fwd got=%h exp=00000110", imem_addr); end
    endtask

    task automatic test_wait_states;
        int stable;
        stable = 0;
        for (int c = 0; c < 4; c++) begin
            if (imem_req === 1'b1 && imem_addr === 32'h0000_0110) stable++;
            if (c < 3) @(negedge clk);
        end
        total++; if (stable !== 4) begin bad++; $display("FAIL wait_stable got=%0d exp=4", stable); end
        run_fetch(32'hCAFE_0110, 0);
        total++; if (instr_valid !== 1'b1 || instr !== 32'hCAFE_0110) begin bad++; $display("FAIL wait_capture got=%b/%h exp=1/cafe0110", instr_valid, instr); end
        imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF; jr = 1'b1; jr_addr = 32'h0000_8000;
        repeat (2) @(negedge clk);
        imem_ack = 1'b0; jr = 1'b0; jr_addr = '0;
        total++; if (instr !== 32'hCAFE_0110 || instr_valid !== 1'b1 || pc_out !== 32'h0000_0110) begin
            bad++; $display("FAIL hold_ignore got=%h/%b/%h exp=cafe0110/1/00000110", instr, instr_valid, pc_out); end
        run_accept(1'b0, '0, 1'b0, '0, 1'b0, '0);
        total++; if (instr !== 32'hCAFE_0110 || instr_valid !== 1'b0) begin bad++; $display("FAIL accept_keep got=%h/%b exp=cafe0110/0", instr, instr_valid); end
        instr_accept = 1'b1; jr = 1'b1; jr_addr = 32'h0000_9000;
        @(negedge clk);
        instr_accept = 1'b0; jr = 1'b0; jr_addr = '0;
        total++; if (pc_out !== 32'h0000_0114 || imem_req !== 1'b1 || retired_count !== exp_ret) begin
            bad++; $display("FAIL idle_accept got=%h/%b/%0d exp=00000114/1/%0d", pc_out, imem_req, retired_count, exp_ret); end
    endtask

    task automatic test_wrap;
        run_fetch(32'hEEEE_0001, 0);
        run_accept(1'b1, 32'hFFFF_FFFE, 1'b0, '0, 1'b0, '0);
        total++; if (imem_addr !== 32'hFFFF_FFFC) begin bad++; $display("FAIL wrap_setup got=%h exp=fffffffc", imem_addr); end
        run_fetch(32'hEEEE_0002, 0);
        total++; if (pc_plus4 !== 32'h0) begin bad++; $display("FAIL wrap_plus4 got=%h exp=00000000", pc_plus4); end
        run_accept(1'b0, '0, 1'b0, '0, 1'b0, '0);
        total++; if (imem_addr !== 32'h0 || retired_count !== exp_ret) begin bad++; $display("FAIL wrap_next got=%h/%0d exp=0/%0d", imem_addr, retired_count, exp_ret); end
    endtask

    task automatic test_async_reset;
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        total++; if (imem_req !== 1'b0 || instr_valid !== 1'b0 || instr !== 32'h0 || retired_count !== 32'h0 || pc_out !== RPC) begin
            bad++; $display("FAIL async_rst got=%b/%b/%h/%0d/%h exp=0/0/0/0/%h", imem_req, instr_valid, instr, retired_count, pc_out, RPC); end
        exp_ret = 32'd0;
        @(negedge clk);
        rst_n = 1'b1;
        total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL async_idle got=%b exp=0", imem_req); end
        @(negedge clk);
        total++; if (imem_req !== 1'b1 || imem_addr !== RPC) begin bad++; $display("FAIL async_restart got=%b/%h exp=1/%h", imem_req, imem_addr, RPC); end
        run_fetch(32'h1234_5678, 2);
        total++; if (instr_valid !== 1'b1 || instr !== 32'h1234_5678 || pc_out !== RPC) begin
            bad++; $display("FAIL async_late_ack got=%b/%h/%h exp=1/12345678/%h", instr_valid, instr, pc_out, RPC); end
        run_accept(1'b0, '0, 1'b0, '0, 1'b0, '0);
        total++; if (retired_count !== 32'd1 || imem_addr !== RPC + 32'd4) begin bad++; $display("FAIL async_resume got=%0d/%h exp=1/%h", retired_count, imem_addr, RPC + 32'd4); end
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_priority();
        test_branch();
        test_wait_states();
        test_wrap();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
